post_host_input: RTL

//  Host-side initiator for the POST REQ/ACK link: drives testreq pulses to a pod and samples testack.

---
 rtl/post_host_pkg.sv | 38 +++
 rtl/post_pulse_gen.sv | 85 ++++++++
 rtl/post_host_input.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/post_host_pkg.sv
// ============================================================================
// Module  : post_host_pkg
// Brief   : Shared state encodings and protocol constants for the POST host.
// Revision: 1.0
// ============================================================================
`default_nettype none

package post_host_pkg;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CMD   = 3'd2,
        ST_POLL  = 3'd3,
        ST_DATA  = 3'd4,
        ST_CHAIN = 3'd5,
        ST_BRK   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_HIGH = 2'd1,
        PG_LOW  = 2'd2
    } pg_state_t;

    localparam int SYNC_PULSES      = 4;
    localparam int CMD_INPUT_PULSES = 4;
    localparam int DATA_BITS        = 8;

    // Pulse-index compare values sized to the 3-bit sequencing counter
    localparam logic [2:0] SYNC_LAST = 3'(SYNC_PULSES - 1);
    localparam logic [2:0] SYNC_BRK  = 3'(SYNC_PULSES);
    localparam logic [2:0] CMD_LAST  = 3'(CMD_INPUT_PULSES - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

endpackage

`default_nettype wire

// File: rtl/post_pulse_gen.sv
// ============================================================================
// Module  : post_pulse_gen
// Brief   : Emits one REQ pulse (high then gap) or one break, samples ACK.
// Revision: 1.0
// ============================================================================
`default_nettype none

module post_pulse_gen
    import post_host_pkg::*;
#(
    parameter int PWID_CYC  = 1,
    parameter int PGAP_CYC  = 1,
    parameter int BREAK_CYC = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic brk,
    input  logic ack,
    output logic req,
    output logic idle,
    output logic done,
    output logic ack_smp
);

    localparam int MAX_CYC = (PWID_CYC > PGAP_CYC)
                           ? ((PWID_CYC > BREAK_CYC) ? PWID_CYC : BREAK_CYC)
                           : ((PGAP_CYC > BREAK_CYC) ? PGAP_CYC : BREAK_CYC);
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] WID_LD = CW'(PWID_CYC - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(PGAP_CYC - 1);
    localparam logic [CW-1:0] BRK_LD = CW'(BREAK_CYC - 1);

    pg_state_t     state;
    logic [CW-1:0] cnt;
    logic [1:0]    ack_sync;

    assign idle = (state == PG_IDLE);
    // done is the last gap cycle so a follow-on go restarts with no dead cycle
    assign done = (state == PG_LOW) && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PG_IDLE;
            cnt      <= '0;
            req      <= 1'b0;
            ack_sync <= 2'b00;
            ack_smp  <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[0], ack};
            case (state)
                PG_HIGH: begin
                    if (cnt == '0) begin
                        ack_smp <= ack_sync[1];
                        req     <= 1'b0;
                        state   <= PG_LOW;
                        cnt     <= GAP_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (state == PG_IDLE || cnt == '0) begin
                        if (go && brk) begin
                            state <= PG_LOW;
                            cnt   <= BRK_LD;
                        end else if (go) begin
                            state <= PG_HIGH;
                            req   <= 1'b1;
                            cnt   <= WID_LD;
                        end else begin
                            state <= PG_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/post_host_input.sv
// ============================================================================
// Module  : post_host_input
// Brief   : POST REQ/ACK host initiator: sync, INPUT command, polling, byte rx.
//           Optional poll timeout enabled by macro POST_HOST_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module post_host_input
    import post_host_pkg::*;
#(
    parameter int PWID_CYC  = 1,
    parameter int PGAP_CYC  = 1,
    parameter int BREAK_CYC = 50
`ifdef POST_HOST_TIMEOUT_EN
    ,
    parameter int MAX_POLL  = 255
`endif
) (
    input  logic       refclk,
    input  logic       reset,
    output logic       testreq,
    input  logic       testack,
    input  logic       rd_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_timeout,
    output logic       busy
);

    state_t     state;
    logic [2:0] pcnt;
    logic [7:0] sr;
    logic       go;
    logic       brk;
    logic       pg_idle;
    logic       pg_done;
    logic       y;
    logic       to_hit;

    post_pulse_gen #(
        .PWID_CYC  (PWID_CYC),
        .PGAP_CYC  (PGAP_CYC),
        .BREAK_CYC (BREAK_CYC)
    ) u_pulse_gen (
        .clk     (refclk),
        .reset   (reset),
        .go      (go),
        .brk     (brk),
        .ack     (testack),
        .req     (testreq),
        .idle    (pg_idle),
        .done    (pg_done),
        .ack_smp (y)
    );

    // Every step except the end of SYNC's break and of BRK launches another pulse or break
    always_comb begin
        go  = 1'b0;
        brk = 1'b0;
        if (pg_idle) begin
            go  = (state != ST_IDLE);
            brk = (state == ST_BRK);
        end else if (pg_done) begin
            go  = !((state == ST_SYNC && pcnt == SYNC_BRK) ||
                    state == ST_BRK || state == ST_IDLE);
            brk = (state == ST_SYNC && pcnt == SYNC_LAST) ||
                  (state == ST_POLL && !y && to_hit) ||
                  (state == ST_DATA && pcnt == DATA_LAST && !rd_req);
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state    <= ST_SYNC;
            pcnt     <= 3'd0;
            sr       <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pcnt <= 3'd0;
                    if (rd_req) begin
                        state <= ST_CMD;
                        busy  <= 1'b1;
                    end
                end
                ST_SYNC: if (pg_done) begin
                    if (pcnt == SYNC_BRK) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pcnt  <= 3'd0;
                    end else begin
                        pcnt <= pcnt + 3'd1;
                    end
                end
                ST_CMD: if (pg_done) begin
                    if (pcnt == CMD_LAST) begin
                        state <= y ? ST_DATA : ST_POLL;
                        pcnt  <= 3'd0;
                    end else begin
                        pcnt <= pcnt + 3'd1;
                    end
                end
                ST_POLL: if (pg_done) begin
                    if (y) begin
                        state <= ST_DATA;
                        pcnt  <= 3'd0;
                    end else if (to_hit) begin
                        state <= ST_BRK;
                    end
                end
                ST_DATA: if (pg_done) begin
                    sr <= {sr[6:0], y};
                    if (pcnt == DATA_LAST) begin
                        rx_data  <= {sr[6:0], y};
                        rx_valid <= 1'b1;
                        state    <= rd_req ? ST_CHAIN : ST_BRK;
                        pcnt     <= 3'd0;
                    end else begin
                        pcnt <= pcnt + 3'd1;
                    end
                end
                ST_CHAIN: if (pg_done) begin
                    state <= y ? ST_DATA : ST_POLL;
                    pcnt  <= 3'd0;
                end
                ST_BRK: if (pg_done) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_SYNC;
                    pcnt  <= 3'd0;
                end
            endcase
        end
    end

`ifdef POST_HOST_TIMEOUT_EN
    logic [7:0] poll_cnt;

    assign to_hit = (poll_cnt == 8'(MAX_POLL - 1));

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            poll_cnt   <= 8'h00;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= 1'b0;
            if (pg_done) begin
                if ((state == ST_CMD && pcnt == CMD_LAST) || state == ST_CHAIN) begin
                    poll_cnt <= 8'h00;
                end else if (state == ST_POLL && !y) begin
                    rx_timeout <= to_hit;
                    if (poll_cnt != 8'hFF) begin
                        poll_cnt <= poll_cnt + 8'd1;
                    end
                end
            end
        end
    end
`else
    assign to_hit     = 1'b0;
    assign rx_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
